crossbar_switch_barrel_pipe: RTL

- Pipelined, flow-controlled N-port crossbar switch built on a log-depth barrel rotator.
- Each accepted beat carries N words of W bits. The beat is circularly rotated by a per-beat shift, in either direction.
- The shift comes from the input (static mode) or from an internal round-robin counter (auto/TDM mode), giving all-to-all connectivity over N beats.
- Sits between the port input registers and the output port logic of the switch fabric.

---
 rtl/crossbar_switch_barrel_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/crossbar_switch_barrel_pipe.sv
// ---------------------------------------------------------------------------
// crossbar_switch_barrel_pipe
//
// Pipelined, flow-controlled N-port crossbar built on a log-depth barrel
// rotator. Each accepted beat carries N words of W bits and is circularly
// rotated by a per-beat shift, either up or down. The shift comes from
// in_shift (static mode) or from an internal round-robin counter (auto/TDM
// mode), which gives all-to-all connectivity over N consecutive beats.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   in_data    N input port words
//   in_shift   rotation amount in static mode (values >= N wrap mod N)
//   mode       0 = static (in_shift), 1 = auto (internal rot_cnt)
//   dir        0 = rotate up, 1 = rotate down
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_data   N switched port words
//   out_shift  effective shift applied to this beat, reduced mod N
//
// Latency is S = $clog2(N) cycles with a throughput of one beat per cycle.
// The whole pipe advances together; a stalled output freezes every stage.
// ---------------------------------------------------------------------------
module crossbar_switch_barrel_pipe #(
   parameter int  N = 8,
   parameter int  W = 8,
   localparam int S = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0][W-1:0] in_data,
   input  logic [S-1:0]        in_shift,
   input  logic                mode,
   input  logic                dir,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0][W-1:0] out_data,
   output logic [S-1:0]        out_shift
);

   // N <= 2^S, so N always fits in S+1 bits even when it is a power of two.
   localparam logic [S:0]   n_ext    = (S+1)'(N);
   localparam logic [S-1:0] cnt_last = S'(N - 1);

   logic         adv;
   logic [S-1:0] rot_cnt;
   logic [S:0]   shift_ext;
   logic [S-1:0] eff;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;

   // in_shift < 2^S < 2N, so a single conditional subtract reduces it mod N.
   // NOTE: every branch assigns eff; a missing else here would infer a latch.
   always_comb begin
      shift_ext = {1'b0, in_shift};
      if (mode)
         eff = rot_cnt;
      else if (shift_ext >= n_ext)
         eff = S'(shift_ext - n_ext);
      else
         eff = in_shift;
   end

   // Round-robin shift source for auto mode; the beat uses the value before
   // the increment.
   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst)
         rot_cnt <= '0;
      else if (in_valid && in_ready && mode)
         rot_cnt <= (rot_cnt == cnt_last) ? '0 : rot_cnt + 1'b1;
   end

   // Stage k rotates by (2^k mod N) when bit k of the beat's shift is set.
   // Composing these partial rotations mod N yields the full rotation even
   // for non-power-of-two N.
   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int amt = (1 << k) % N;

      logic [N-1:0][W-1:0] d_in;
      logic [N-1:0][W-1:0] d_rot;
      logic                v_in;
      logic [S-1:0]        s_in;
      logic                r_in;

      logic [N-1:0][W-1:0] q_data;
      logic                q_valid;
      logic [S-1:0]        q_shift;
      logic                q_dir;

      if (k == 0) begin : g_src
         assign d_in = in_data;
         assign v_in = in_valid;
         assign s_in = eff;
         assign r_in = dir;
      end else begin : g_src
         assign d_in = g_stage[k-1].q_data;
         assign v_in = g_stage[k-1].q_valid;
         assign s_in = g_stage[k-1].q_shift;
         assign r_in = g_stage[k-1].q_dir;
      end

      // Up:   out[(j+amt) mod N] = in[j]  ->  out[j] = in[(j-amt) mod N]
      // Down: out[j] = in[(j+amt) mod N]
      for (genvar j = 0; j < N; j++) begin : g_lane
         localparam int up_src = (j + N - amt) % N;
         localparam int dn_src = (j + amt) % N;
         assign d_rot[j] = !s_in[k] ? d_in[j]
                         : (r_in ? d_in[dn_src] : d_in[up_src]);
      end

      // NOTE: stage data is reset too so that out_data reads 0 after reset;
      // the valid bit alone would not guarantee that.
      always_ff @(posedge clk) begin
         if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_shift <= '0;
            q_dir   <= 1'b0;
         end else if (adv) begin
            q_valid <= v_in;
            q_data  <= d_rot;
            q_shift <= s_in;
            q_dir   <= r_in;
         end
      end
   end

   assign out_valid = g_stage[S-1].q_valid;
   assign out_data  = g_stage[S-1].q_data;
   assign out_shift = g_stage[S-1].q_shift;

endmodule
